// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    FETCH   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Instruction substituted when a fetch times out (MOV r0,r0).
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A00000;

  // Width of the bus timeout counter.
  localparam int unsigned TMO_CTR_W = 8;

  // True in the states that own the bus and are waiting for BusAck.
  function automatic logic is_bus_phase(input arb_state_e st);
    return (st == DATA) || (st == FETCH);
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: saturating clear/enable cycle counter with a terminal-count flag.
module bus_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter logic [TMO_CTR_W-1:0] TC_VALUE = 8'd254
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_CTR_W-1:0] CNT_ZERO = {TMO_CTR_W{1'b0}};
  localparam logic [TMO_CTR_W-1:0] CNT_MAX  = {TMO_CTR_W{1'b1}};
  localparam logic [TMO_CTR_W-1:0] CNT_ONE  = {{(TMO_CTR_W-1){1'b0}}, 1'b1};

  logic [TMO_CTR_W-1:0] count_q;
  logic [TMO_CTR_W-1:0] count_d;

  // Clear wins over enable; the count sticks at all-ones rather than wrapping
  always_comb begin
    if (clr) begin
      count_d = CNT_ZERO;
    end else if (en && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory bus between the MEM-stage
// data access and instruction fetch. Data goes first, then fetch; the pipeline is
// held with StallMem until both are done. Timed-out accesses are aborted, replaced
// by a safe value, and recorded in a sticky Fault flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] InstrF,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck,
  output logic        Fault
);

  // Counter value at which an unacknowledged access is abandoned.
  localparam logic [TMO_CTR_W-1:0] TMO_LAST = TMO_CTR_W'(TIMEOUT_CYCLES - 32'd1);

  arb_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        stall_q, stall_d;

  logic        in_access_s;
  logic        tmo_tc_s;
  logic        tmo_en_s;
  logic        tmo_clr_s;
  logic        abort_s;

  // BusAck only matters while an access is outstanding; an ack on the
  // terminal-count edge still counts as a normal completion.
  assign in_access_s = is_bus_phase(state_q);
  assign tmo_en_s    = in_access_s & ~BusAck;
  assign abort_s     = in_access_s & ~BusAck & tmo_tc_s;
  assign tmo_clr_s   = (state_d != state_q) & is_bus_phase(state_d);

  bus_timeout_ctr #(
    .TC_VALUE (TMO_LAST)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr_s),
    .en    (tmo_en_s),
    .tc    (tmo_tc_s)
  );

  // Next-state, read-data capture and fault decisions
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          state_d = DATA;
        end else begin
          state_d = FETCH;
        end
      end
      DATA: begin
        if (BusAck) begin
          if (!bus_we_q) begin
            rdata_d = BusRData;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = FETCH;
        end else if (abort_s) begin
          if (!bus_we_q) begin
            rdata_d = 32'h0000_0000;
          end else begin
            rdata_d = rdata_q;
          end
          fault_d = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = DATA;
        end
      end
      FETCH: begin
        if (BusAck) begin
          instr_d = BusRData;
          state_d = RELEASE;
        end else if (abort_s) begin
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          state_d = RELEASE;
        end else begin
          state_d = FETCH;
        end
      end
      RELEASE: begin
        // MemReqM here belongs to the instruction entering MEM
        if (MemReqM) begin
          state_d = DATA;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus request registers are loaded only on a state change, so they stay
  // stable for the whole access; the stall flag decodes the next state.
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if (state_d != state_q) begin
      case (state_d)
        DATA: begin
          bus_req_d   = 1'b1;
          bus_we_d    = MemWriteM;
          bus_addr_d  = ALUOutM;
          bus_wdata_d = WriteDataM;
        end
        FETCH: begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = PCF;
        end
        RELEASE: begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end
        default: begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end
      endcase
    end else begin
      bus_req_d = bus_req_q;
    end
    stall_d = (state_d != RELEASE);
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      instr_q     <= NOP_INSTR;
      rdata_q     <= 32'h0000_0000;
      fault_q     <= 1'b0;
      stall_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      stall_q     <= stall_d;
    end
  end

  assign InstrF    = instr_q;
  assign ReadDataM = rdata_q;
  assign StallMem  = stall_q;
  assign BusReq    = bus_req_q;
  assign BusWe     = bus_we_q;
  assign BusAddr   = bus_addr_q;
  assign BusWData  = bus_wdata_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed reset/spurious-ack checks followed by randomized
// instruction slots checked through a scoreboard against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned T     = 4;
  localparam logic [31:0] NOP   = 32'hE1A00000;
  localparam int          N_INS = 60;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  typedef struct packed {
    int          delay;
    logic [31:0] rdata;
  } slv_rsp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rdata;
    logic        fault;
    int          stall;
  } rel_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF = 32'h0;
  logic        MemReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] InstrF, ReadDataM, BusAddr, BusWData;
  logic        StallMem, BusReq, BusWe, Fault;
  logic [31:0] BusRData = 32'h0;
  logic        BusAck = 1'b0;

  int checks = 0;
  int failures = 0;

  bus_txn_t exp_bus_q[$];
  slv_rsp_t slv_q[$];
  rel_t     exp_rel_q[$];

  // model state (architectural view of the outputs)
  logic [31:0] m_instr;
  logic [31:0] m_rdata;
  logic        m_fault;

  // directed-phase ack control, forwarded by the slave process
  logic        dir_ack = 1'b0;
  logic [31:0] dir_rdata = 32'h0;
  bit          slv_en = 1'b0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .InstrF(InstrF), .ReadDataM(ReadDataM),
    .StallMem(StallMem), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
    .BusWData(BusWData), .BusRData(BusRData), .BusAck(BusAck), .Fault(Fault)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic int pick_delay(input int k);
    int r;
    r = int'($urandom_range(0, 7));
    case (r)
      0, 1, 2, 3: return r % 3;
      4:          return int'(T) - 1;
      5:          return (k < 10) ? int'(T) - 1 : int'(T);
      6:          return (k < 10) ? 1 : int'(T) + 3;
      default:    return 0;
    endcase
  endfunction

  // Drive one instruction slot and record what the spec says must happen.
  task automatic issue(input int k);
    logic        memreq, we;
    logic [31:0] a, wd, pc, rd_d, rd_f;
    int          dd, df, st;
    memreq = ($urandom_range(0, 3) != 0);
    we     = ($urandom_range(0, 1) == 1);
    a      = $urandom;
    wd     = $urandom;
    pc     = $urandom & 32'hFFFF_FFFC;
    rd_d   = $urandom;
    rd_f   = $urandom;
    dd     = pick_delay(k);
    df     = pick_delay(k);
    MemReqM = memreq; MemWriteM = we; ALUOutM = a; WriteDataM = wd; PCF = pc;
    st = 0;
    if (memreq) begin
      exp_bus_q.push_back('{we: we, addr: a, wdata: wd});
      slv_q.push_back('{delay: dd, rdata: rd_d});
      if (dd < int'(T)) begin
        st += dd + 1;
        if (!we) m_rdata = rd_d;
      end else begin
        st += int'(T);
        m_fault = 1'b1;
        if (!we) m_rdata = 32'h0;
      end
    end
    exp_bus_q.push_back('{we: 1'b0, addr: pc, wdata: 32'h0});
    slv_q.push_back('{delay: df, rdata: rd_f});
    if (df < int'(T)) begin
      st += df + 1;
      m_instr = rd_f;
    end else begin
      st += int'(T);
      m_instr = NOP;
      m_fault = 1'b1;
    end
    exp_rel_q.push_back('{instr: m_instr, rdata: m_rdata, fault: m_fault, stall: st});
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (StallMem === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Bus slave: acks after the scheduled delay; treats an unacked access as
  // abandoned after T cycles.
  initial begin : slave
    int       slv_cyc;
    bit       slv_fresh;
    slv_rsp_t cur;
    slv_cyc = 0;
    slv_fresh = 1'b1;
    cur = '{delay: 0, rdata: 32'h0};
    forever begin
      @(negedge clk);
      if (!slv_en) begin
        BusAck = dir_ack;
        BusRData = dir_rdata;
        slv_fresh = 1'b1;
      end else if (BusReq) begin
        if (slv_fresh) begin
          if (slv_q.size() == 0) begin
            fail_now("slave_underflow");
            cur = '{delay: 1000, rdata: 32'h0};
          end else begin
            cur = slv_q.pop_front();
          end
          slv_cyc = 0;
        end
        if (slv_cyc == cur.delay) begin
          BusAck = 1'b1;
          BusRData = cur.rdata;
          slv_fresh = 1'b1;
        end else begin
          BusAck = 1'b0;
          BusRData = $urandom;
          slv_fresh = (slv_cyc == int'(T) - 1);
        end
        slv_cyc++;
      end else begin
        BusAck = 1'b0;
        slv_fresh = 1'b1;
      end
    end
  end

  // Monitor: checks each new bus request, bus stability, and each release.
  initial begin : monitor
    bit       prev_req, ack_edge;
    int       mcyc, stall_cnt;
    bus_txn_t hold, e;
    rel_t     r;
    prev_req = 1'b0; mcyc = 0; stall_cnt = 0;
    hold = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
    forever begin
      @(posedge clk);
      ack_edge = BusAck;
      @(negedge clk);
      if (mon_en) begin
        if (BusReq) begin
          if (!prev_req || ack_edge || mcyc == int'(T)) begin
            if (exp_bus_q.size() == 0) begin
              fail_now("bus_unexpected");
            end else begin
              e = exp_bus_q.pop_front();
              chk("bus_we_addr", 96'({BusWe, BusAddr}), 96'({e.we, e.addr}));
              if (e.we) chk("bus_wdata", 96'(BusWData), 96'(e.wdata));
            end
            hold = '{we: BusWe, addr: BusAddr, wdata: BusWData};
            mcyc = 1;
          end else begin
            chk("bus_stable", 96'({BusWe, BusAddr, BusWData}),
                96'({hold.we, hold.addr, hold.wdata}));
            mcyc++;
          end
        end else begin
          mcyc = 0;
        end
        prev_req = BusReq;
        if (StallMem === 1'b0) begin
          if (exp_rel_q.size() == 0) begin
            fail_now("release_unexpected");
          end else begin
            r = exp_rel_q.pop_front();
            chk("instr", 96'(InstrF), 96'(r.instr));
            chk("rdata", 96'(ReadDataM), 96'(r.rdata));
            chk("fault", 96'(Fault), 96'(r.fault));
            chk("stall_cycles", 96'(stall_cnt), 96'(r.stall));
          end
          stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end else begin
        prev_req = 1'b0; mcyc = 0; stall_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    bit aborted;
    aborted = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 96'(StallMem), 96'(1'b1));
    chk("rst_busreq", 96'({BusReq, BusWe}), 96'(2'b00));
    chk("rst_busaddr", 96'({BusAddr, BusWData}), 96'(64'h0));
    chk("rst_instr", 96'(InstrF), 96'(NOP));
    chk("rst_rdata_fault", 96'({ReadDataM, Fault}), 96'(33'h0));

    // Abandon a load in flight with reset
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h100; PCF = 32'h40;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("data_req", 96'({BusReq, BusWe, BusAddr, StallMem}), 96'({1'b1, 1'b0, 32'h100, 1'b1}));
    #2 reset = 1'b1;
    #1 chk("async_rst", 96'({BusReq, StallMem}), 96'(2'b01));

    // Spurious ack in IDLE must be ignored
    MemReqM = 1'b0; dir_ack = 1'b1; dir_rdata = 32'hBADC0DE0;
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    dir_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", 96'({InstrF, ReadDataM}), 96'({NOP, 32'h0}));
    chk("fetch_req", 96'({BusReq, BusWe, BusAddr, StallMem}), 96'({1'b1, 1'b0, 32'h40, 1'b1}));
    #1 dir_ack = 1'b1; dir_rdata = 32'hE3A01005;
    @(negedge clk);
    #1 dir_ack = 1'b0;
    @(negedge clk);
    chk("fetch_capture", 96'({InstrF, StallMem, BusReq, Fault}), 96'({32'hE3A01005, 3'b000}));
    @(negedge clk);
    chk("release_one_cycle", 96'({StallMem, BusReq}), 96'(2'b11));

    // Randomized phase
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    m_instr = NOP; m_rdata = 32'h0; m_fault = 1'b0;
    exp_bus_q.delete(); slv_q.delete(); exp_rel_q.delete();
    issue(0);
    #1 reset = 1'b0; slv_en = 1'b1; mon_en = 1'b1;
    for (int k = 1; k < N_INS && !aborted; k++) begin
      wait_release(ok);
      if (!ok) begin
        fail_now("release_wait");
        aborted = 1'b1;
      end else begin
        issue(k);
      end
    end
    if (!aborted) begin
      wait_release(ok);
      if (!ok) fail_now("release_wait_last");
    end
    #1 mon_en = 1'b0; slv_en = 1'b0;
    chk("queues_drained", 96'(exp_rel_q.size() + exp_bus_q.size() + slv_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
